instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the 8-bit register-file datapath/decoder pair.
//  Owns the 8-bit program counter and fetches 16-bit words from instruction memory.
//  Splits each word into opcode/dr/sa/sb for the decoder and asserts exec_en for one cycle per instruction.
//  Resolves jumps and conditional branches from decoder PL/JB/BC, datapath status flags and register-A output.
// PARAMETERS
//  PC_W      8       program counter / instruction address width
//  RESET_PC  8'h00   PC value loaded on reset and on start
//  HALT_OP   7'h7F   opcode that stops sequencing
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   begin execution from RESET_PC (sampled in IDLE/HALT only)
//  imem_addr   out  8   instruction address (= pc)
//  imem_rd     out  1   instruction read strobe; data valid on instr_in next cycle
//  instr_in    in   16  instruction word {opcode[15:9], dr[8:6], sa[5:3], sb[2:0]}
//  opcode      out  7   latched opcode to decoder
//  dr, sa, sb  out  3   latched register fields to decoder
//  exec_en     out  1   one-cycle execute qualifier; top ANDs it with RW and MW
//  pl, jb, bc  in   1   decoder: load PC / jump(1) vs branch(0) / branch condition select
//  ad_in       in   8   datapath register-A bus (jump target)
//  z_flag      in   1   datapath zero flag, valid during exec_en
//  n_flag      in   1   datapath negative flag, valid during exec_en
//  busy        out  1   high from FETCH through EXEC
//  halted      out  1   high in HALT state
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_rd=0, opcode/dr/sa/sb=0,
//   exec_en=0, busy=0, halted=0. Takes effect immediately, including mid-instruction; no partial exec.
//  States: IDLE -> FETCH -> LATCH -> EXEC -> FETCH ... ; EXEC -> HALT on HALT_OP.
//  IDLE : start=1 -> pc<=RESET_PC, go FETCH. Otherwise hold.
//  FETCH: imem_rd=1, imem_addr=pc; busy=1. Next: LATCH.
//  LATCH: capture instr_in into opcode/dr/sa/sb (1-cycle memory latency). Next: EXEC.
//  EXEC : exec_en=1 for exactly this cycle. Register/memory write occurs on the exiting edge.
//   If opcode==HALT_OP: exec_en forced 0, pc unchanged, go HALT.
//   Otherwise next pc, in priority order:
//    pl=1 & jb=1                 -> pc <= ad_in
//    pl=1 & jb=0 & (bc?n:z)=1    -> pc <= pc + sext({dr,sb}) (6-bit two's-complement offset, -32..+31)
//    else                        -> pc <= pc + 1
//   Then go FETCH.
//  Latency: 3 cycles per instruction. Throughput: one instruction / 3 clk.
//  Arithmetic: pc is modulo 2^PC_W. 8'hFF+1 -> 8'h00; 8'h02 + (-5) -> 8'hFD. No overflow flag.
//  HALT: halted=1, busy=0, fields hold last value. start=1 -> pc<=RESET_PC, halted<=0, go FETCH.
//  start while busy: ignored. Flags and ad_in are sampled only in EXEC.
//  imem_rd and exec_en are never high in the same cycle.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: adds input step (1 bit).
//   From EXEC, the sequencer goes to a WAIT state instead of FETCH; busy stays 1.
//   It leaves WAIT for FETCH on the first clk with step=1. HALT behaviour is unchanged.
//   A step held high advances one instruction per 4 cycles.
//  SEQ_SINGLE_STEP_EN undefined: no step port, no WAIT state; runs free as described above.
// TESTING
//  1. Reset then start, imem[0..2] = non-branch ops, imem[3] = HALT_OP:
//     -> imem_addr 0,1,2,3; exec_en pulses 3 times, 3 cycles apart; halted=1 with pc=3.
//  2. Branch taken/not taken: pc=8'h10, pl=1, jb=0, bc=0, {dr,sb}=6'h3E (-2):
//     z=1 -> next fetch at 8'h0E; z=0 -> 8'h11. Repeat with bc=1 on n_flag.
//  3. Jump: pl=1, jb=1, ad_in=8'hA5 -> next imem_addr=8'hA5, regardless of z/n.
//  4. Wrap: pc=8'hFF, non-branch op -> next fetch at 8'h00. pc=8'h02, offset -5, taken -> 8'hFD.
//  5. Reset mid-op: drop rst_n during EXEC -> exec_en=0 and pc=RESET_PC in the same cycle; idle until start.
//  6. With SEQ_SINGLE_STEP_EN: step=0 -> sequencer holds in WAIT after exec_en;
//     one step pulse -> exactly one more instruction executes.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit register-file datapath.
// Owns the program counter, fetches 16-bit instruction words, presents the
// opcode/dr/sa/sb fields to the decoder and issues one exec_en per instruction.
// Jumps and conditional branches are resolved from decoder pl/jb/bc, the
// datapath z/n flags and the register-A bus.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds the step input and a WAIT
// state between instructions).
module instr_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [6:0]      HALT_OP  = 7'h7F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     instr_in,
  output logic [6:0]      opcode,
  output logic [2:0]      dr,
  output logic [2:0]      sa,
  output logic [2:0]      sb,
  output logic            exec_en,
  input  logic            pl,
  input  logic            jb,
  input  logic            bc,
  input  logic [PC_W-1:0] ad_in,
  input  logic            z_flag,
  input  logic            n_flag,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
`ifdef SEQ_SINGLE_STEP_EN
    S_WAIT,
`endif
    S_HALT
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_imem_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_dr;
  logic [2:0]      r_sa;
  logic [2:0]      r_sb;
  logic            r_exec_en;
  logic            r_busy;
  logic            r_halted;

  logic [5:0]      w_offset;
  logic [PC_W-1:0] w_offset_ext;
  logic            w_cond;
  logic [PC_W-1:0] w_next_pc;

  // Branch offset is the 6-bit two's-complement value {dr,sb}, sign-extended
  // to the PC width; all PC arithmetic wraps modulo 2^PC_W.
  assign w_offset     = {r_dr, r_sb};
  assign w_offset_ext = {{(PC_W-6){w_offset[5]}}, w_offset};
  assign w_cond       = bc ? n_flag : z_flag;
  assign w_next_pc    = (pl && jb)     ? ad_in :
                        (pl && w_cond) ? r_pc + w_offset_ext :
                                         r_pc + PC_W'(1);

  assign imem_addr = r_pc;
  assign imem_rd   = r_imem_rd;
  assign opcode    = r_opcode;
  assign dr        = r_dr;
  assign sa        = r_sa;
  assign sb        = r_sb;
  assign exec_en   = r_exec_en;
  assign busy      = r_busy;
  assign halted    = r_halted;

  // Sequencer FSM: state, PC, latched fields and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the field registers are plain flops, not a memory array, so they
      // take a reset value like any other state; async reset also kills an
      // in-flight exec_en immediately.
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_imem_rd <= 1'b0;
      r_opcode  <= '0;
      r_dr      <= '0;
      r_sa      <= '0;
      r_sb      <= '0;
      r_exec_en <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are re-asserted only on the
      // transition into their state; non-blocking assignments keep every
      // branch below reading this cycle's register values.
      r_imem_rd <= 1'b0;
      r_exec_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc      <= RESET_PC;
            r_imem_rd <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_opcode  <= instr_in[15:9];
          r_dr      <= instr_in[8:6];
          r_sa      <= instr_in[5:3];
          r_sb      <= instr_in[2:0];
          r_exec_en <= (instr_in[15:9] != HALT_OP);
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (r_opcode == HALT_OP) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_pc <= w_next_pc;
`ifdef SEQ_SINGLE_STEP_EN
            r_state <= S_WAIT;
`else
            r_imem_rd <= 1'b1;
            r_state   <= S_FETCH;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_WAIT: begin
          if (step) begin
            r_imem_rd <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
`endif
        S_HALT: begin
          if (start) begin
            r_pc      <= RESET_PC;
            r_halted  <= 1'b0;
            r_busy    <= 1'b1;
            r_imem_rd <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed program walks (straight
// line, branches, jumps, wrap-around, reset mid-instruction) followed by a
// randomized program checked against a behavioural next-PC model.
module tb_instr_sequencer;

  localparam logic [6:0] HALT_OP = 7'h7F;

  logic        clk;
  logic        rst_n;
  logic        start;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step;
`endif
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] instr_in;
  logic [6:0]  opcode;
  logic [2:0]  dr, sa, sb;
  logic        exec_en;
  logic        pl, jb, bc;
  logic [7:0]  ad_in;
  logic        z_flag, n_flag;
  logic        busy, halted;

  instr_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .instr_in  (instr_in),
    .opcode    (opcode),
    .dr        (dr),
    .sa        (sa),
    .sb        (sb),
    .exec_en   (exec_en),
    .pl        (pl),
    .jb        (jb),
    .bc        (bc),
    .ad_in     (ad_in),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .busy      (busy),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem [256];
  logic [7:0]  exp_pc;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:9] == HALT_OP) w[15:9] = 7'h00;
    return w;
  endfunction

  // Reference next-PC: plain integer arithmetic on the architectural rules.
  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [15:0] w,
                                            input logic p, input logic j, input logic c,
                                            input logic [7:0] ad, input logic z, input logic n);
    int off;
    int npc;
    off = int'(w[8:6]) * 8 + int'(w[2:0]);
    if (off >= 32) off = off - 64;
    if (p && j) return ad;
    if (p && (c ? n : z)) npc = int'(pc) + off;
    else                  npc = int'(pc) + 1;
    return 8'((npc + 512) % 256);
  endfunction

  task automatic garbage_inputs();
    pl     = 1'($urandom);
    jb     = 1'($urandom);
    bc     = 1'($urandom);
    ad_in  = 8'($urandom);
    z_flag = 1'($urandom);
    n_flag = 1'($urandom);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start  = 1'b0;
    exp_pc = 8'h00;
  endtask

  // Runs one instruction. Entry and exit: just after the edge into FETCH
  // (exit is in HALT for a halt opcode).
  task automatic run_instr(input logic i_pl, input logic i_jb, input logic i_bc,
                           input logic [7:0] i_ad, input logic i_z, input logic i_n);
    logic [15:0] w;
    w = imem[exp_pc];
    // FETCH
    check("fetch_rd", imem_rd, 1'b1);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_no_exec", exec_en, 1'b0);
    check("fetch_busy", busy, 1'b1);
    check("fetch_not_halted", halted, 1'b0);
    garbage_inputs();
    instr_in = 16'($urandom);
    tick();
    // LATCH: memory data arrives one cycle after the read strobe
    instr_in = w;
    start    = 1'($urandom);
    check("latch_rd", imem_rd, 1'b0);
    check("latch_no_exec", exec_en, 1'b0);
    tick();
    // EXEC
    instr_in = 16'($urandom);
    start    = 1'b0;
    check("exec_opcode", opcode, w[15:9]);
    check("exec_dr", dr, w[8:6]);
    check("exec_sa", sa, w[5:3]);
    check("exec_sb", sb, w[2:0]);
    check("exec_no_rd", imem_rd, 1'b0);
    if (w[15:9] == HALT_OP) begin
      check("halt_no_exec", exec_en, 1'b0);
      garbage_inputs();
      tick();
      check("halt_flag", halted, 1'b1);
      check("halt_busy", busy, 1'b0);
      check("halt_pc", imem_addr, exp_pc);
      check("halt_no_rd", imem_rd, 1'b0);
      tick();
      check("halt_hold_opcode", opcode, w[15:9]);
      check("halt_hold_flag", halted, 1'b1);
    end else begin
      check("exec_en", exec_en, 1'b1);
      pl = i_pl; jb = i_jb; bc = i_bc; ad_in = i_ad; z_flag = i_z; n_flag = i_n;
      exp_pc = model_next(exp_pc, w, i_pl, i_jb, i_bc, i_ad, i_z, i_n);
      tick();
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'b0;
      garbage_inputs();
      check("wait_no_rd", imem_rd, 1'b0);
      check("wait_busy", busy, 1'b1);
      tick();
      check("wait_hold", imem_rd, 1'b0);
      step = 1'b1;
      tick();
      step = 1'b0;
`endif
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step  = 1'b0;
`endif
    instr_in = 16'h0000;
    garbage_inputs();
    exp_pc = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = rand_op();

    // Reset state
    tick();
    tick();
    check("rst_rd", imem_rd, 1'b0);
    check("rst_exec", exec_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_fields", {opcode, dr, sa, sb}, 16'h0000);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_hold_rd", imem_rd, 1'b0);
    check("idle_hold_busy", busy, 1'b0);

    // Straight-line program ending in HALT
    imem[3] = mk(HALT_OP, 3'h1, 3'h2, 3'h3);
    start_pulse();
    for (int k = 0; k < 4; k++) run_instr(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    check("t1_halt_pc", imem_addr, 8'h03);

    // Branches on z and n with offset -2, jumps, and PC wrap-around
    imem[8'h10] = mk(7'h12, 3'b111, 3'h2, 3'b110);
    imem[8'h02] = mk(7'h21, 3'b111, 3'h5, 3'b011);
    imem[8'hFD] = mk(HALT_OP, 3'h0, 3'h0, 3'h0);
    start_pulse();
    run_instr(1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    check("jump_to_10", imem_addr, 8'h10);
    run_instr(1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
    check("br_z_taken", imem_addr, 8'h0E);
    run_instr(1'b1, 1'b1, 1'($urandom), 8'h10, 1'($urandom), 1'($urandom));
    run_instr(1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1);
    check("br_z_not_taken", imem_addr, 8'h11);
    run_instr(1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    check("br_n_taken", imem_addr, 8'h0E);
    run_instr(1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1);
    run_instr(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check("br_n_not_taken", imem_addr, 8'h11);
    run_instr(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    check("jump_a5", imem_addr, 8'hA5);
    run_instr(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1);
    check("wrap_ff", imem_addr, 8'h00);
    run_instr(1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0);
    check("wrap_neg_offset", imem_addr, 8'hFD);
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset asserted during EXEC
    imem[8'h40] = rand_op();
    start_pulse();
    run_instr(1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
    check("pre_rst_addr", imem_addr, 8'h40);
    tick();
    instr_in = imem[8'h40];
    tick();
    check("pre_rst_exec", exec_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_exec", exec_en, 1'b0);
    check("midrst_pc", imem_addr, 8'h00);
    check("midrst_busy", busy, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_idle_rd", imem_rd, 1'b0);
      check("post_rst_idle_busy", busy, 1'b0);
    end

    // Randomized program against the reference model
    for (int i = 0; i < 256; i++) imem[i] = rand_op();
    start_pulse();
    for (int k = 0; k < 150; k++)
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    imem[exp_pc] = mk(HALT_OP, 3'($urandom), 3'($urandom), 3'($urandom));
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
